multicycle_datapath: RTL

MULTICYCLE_DATAPATH -- requirements
Module: multicycle_datapath

---
 rtl/multicycle_datapath.sv | 112 +++++++++++
 1 files changed

// File: rtl/multicycle_datapath.sv
// Multicycle MIPS-style datapath: PC/IR/MDR/A/B/ALUOut, 32x32 register file, ALU and next-PC muxing.
// Optional DATAPATH_DEBUG_PORT_EN adds a combinational third register-file read port (dbg_raddr/dbg_rdata).
module multicycle_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        PCWriteCond,
    input  logic        IorD,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        IRWrite,
    input  logic        ALUSrcA,
    input  logic        RegWrite,
    input  logic        RegDst,
    input  logic        ALUOp,
    input  logic [1:0]  ALUSrcB,
    input  logic [1:0]  PCSource,
    output logic [5:0]  opCode,
    output logic        zero,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc
`ifdef DATAPATH_DEBUG_PORT_EN
    ,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
`endif
);

    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [31:0] ir, mdr, a_reg, b_reg, alu_out;
    logic [31:0][31:0] rf;
    logic [31:0] alu_a, alu_b, alu_result, imm_ext, next_pc, wr_data;
    logic [4:0]  wr_addr;
    logic        pc_en;

    assign imm_ext   = {{16{ir[15]}}, ir[15:0]};
    assign opCode    = ir[31:26];
    assign mem_addr  = IorD ? alu_out : pc;
    assign mem_wdata = b_reg;
    assign mem_we    = MemWrite;
    assign zero      = (alu_result == 32'd0);
    assign pc_en     = PCWrite | (PCWriteCond & zero);
    assign wr_addr   = RegDst ? ir[15:11] : ir[20:16];
    assign wr_data   = MemtoReg ? mdr : alu_result;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_a = ALUSrcA ? a_reg : pc;
        case (ALUSrcB)
            2'b00:   alu_b = b_reg;
            2'b01:   alu_b = 32'd4;
            2'b10:   alu_b = imm_ext;
            default: alu_b = {imm_ext[29:0], 2'b00};
        endcase
        alu_result = alu_a + alu_b;
        if (!ALUOp) begin
            case (ir[5:0])
                FN_SUB:  alu_result = alu_a - alu_b;
                FN_AND:  alu_result = alu_a & alu_b;
                FN_OR:   alu_result = alu_a | alu_b;
                FN_SLT:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
                default: alu_result = alu_a + alu_b;
            endcase
        end
    end

    always_comb begin
        case (PCSource)
            2'b00:   next_pc = alu_result;
            2'b01:   next_pc = alu_out;
            2'b10:   next_pc = {pc[31:28], ir[25:0], 2'b00};
            default: next_pc = pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            // NOTE: the register file must be cleared on reset, so it is flops rather than a RAM macro.
            rf      <= '0;
        end else begin
            // NOTE: non-blocking updates make every read here see pre-edge values (no bypass, old IR fields).
            if (pc_en)    pc <= next_pc;
            if (IRWrite)  ir <= mem_rdata;
            mdr     <= mem_rdata;
            a_reg   <= rf[ir[25:21]];
            b_reg   <= rf[ir[20:16]];
            alu_out <= alu_result;
            // Register 0 is never written, so it keeps its reset value of zero.
            if (RegWrite && (wr_addr != 5'd0)) rf[wr_addr] <= wr_data;
        end
    end

`ifdef DATAPATH_DEBUG_PORT_EN
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : rf[dbg_raddr];
`endif

endmodule
